bcd_to_bin: RTL

BCD_TO_BIN -- requirements
Module: bcd_to_bin

---
 rtl/bcd_to_bin.sv | 119 +++++++++++
 1 files changed

// File: rtl/bcd_to_bin.sv
// Sequential packed-BCD to binary converter.
// One digit per clock, most significant digit first, using a
// multiply-by-ten-and-add accumulator. A conversion takes DIGITS cycles
// from the accepted start edge to the done pulse. Any digit above 9 marks
// the operand invalid, which forces the result to zero and raises err.
//
// Handshake: start is a request that is sampled only while idle (busy=0).
// The edge that accepts it also latches bcd_in. done pulses for exactly
// one cycle on completion, and bin_out/err are valid from that cycle.
// They then hold until the next completion. Each accepted start yields
// exactly one done pulse unless reset aborts the conversion.
module bcd_to_bin #(
    parameter int DIGITS = 4,
    parameter int BIN_W  = 14
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  start,
    input  logic [4*DIGITS-1:0]   bcd_in,
    output logic [BIN_W-1:0]      bin_out,
    output logic                  done,
    output logic                  busy,
    output logic                  err
);

    localparam int CNT_W = $clog2(DIGITS + 1);

    localparam logic [0:0] IDLE = 1'b0;
    localparam logic [0:0] CONV = 1'b1;

    logic [0:0]          state_q,  state_d;
    logic [4*DIGITS-1:0] shreg_q,  shreg_d;
    logic [BIN_W-1:0]    acc_q,    acc_d;
    logic [CNT_W-1:0]    cnt_q,    cnt_d;
    logic                inv_q,    inv_d;
    logic [BIN_W-1:0]    bin_q,    bin_d;
    logic                err_q,    err_d;
    logic                done_q,   done_d;

    // Datapath for the digit being processed this cycle.
    logic [3:0]          digit;
    logic [BIN_W-1:0]    acc_next;
    logic                inv_next;
    logic                last_digit;

    // Next-state and datapath logic for the two-state converter.
    always_comb begin
        state_d    = state_q;
        shreg_d    = shreg_q;
        acc_d      = acc_q;
        cnt_d      = cnt_q;
        inv_d      = inv_q;
        bin_d      = bin_q;
        err_d      = err_q;
        done_d     = 1'b0;

        digit      = shreg_q[4*DIGITS-1 -: 4];
        acc_next   = (acc_q << 3) + (acc_q << 1) + BIN_W'(digit);
        inv_next   = inv_q | (digit > 4'd9);
        last_digit = (cnt_q == CNT_W'(DIGITS - 1));

        case (state_q)
            IDLE: begin
                if (start) begin
                    shreg_d = bcd_in;
                    acc_d   = '0;
                    cnt_d   = '0;
                    inv_d   = 1'b0;
                    state_d = CONV;
                end
            end
            CONV: begin
                acc_d   = acc_next;
                inv_d   = inv_next;
                shreg_d = shreg_q << 4;
                cnt_d   = cnt_q + 1'b1;
                if (last_digit) begin
                    // An invalid operand reports zero rather than a partial value.
                    bin_d   = inv_next ? '0 : acc_next;
                    err_d   = inv_next;
                    done_d  = 1'b1;
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State registers with synchronous active-low reset; reset aborts any conversion.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q <= IDLE;
            shreg_q <= '0;
            acc_q   <= '0;
            cnt_q   <= '0;
            inv_q   <= 1'b0;
            bin_q   <= '0;
            err_q   <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            shreg_q <= shreg_d;
            acc_q   <= acc_d;
            cnt_q   <= cnt_d;
            inv_q   <= inv_d;
            bin_q   <= bin_d;
            err_q   <= err_d;
            done_q  <= done_d;
        end
    end

    assign bin_out = bin_q;
    assign err     = err_q;
    assign done    = done_q;
    assign busy    = (state_q == CONV);

endmodule
